score_ctrl: RTL and testbench
=============================

Name: score_ctrl

Overview:
Scheduler and game-level controller in front of the 4-digit BCD score datapath. It arbitrates asteroid-hit events from several bullet/collision requesters and converts each granted hit into a size-weighted BCD score increment. It also tracks lives, a high score and the game state (idle / play / dying / over). It sits between the collision logic and the HEX display drivers.

Parameters:
NUM_REQ, 4, number of hit requesters (2..8)
PTS_LARGE, 16'h0020, BCD points for a large asteroid
PTS_MED, 16'h0050, BCD points for a medium asteroid
PTS_SMALL, 16'h0100, BCD points for a small asteroid
START_LIVES, 3, lives loaded on game start (1..7)
DEATH_CYCLES, 8, clocks spent in DYING after a ship hit (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  level; begins a game from IDLE or OVER
hit_req  in  NUM_REQ  per-requester hit request, held high until acked
hit_size  in  2*NUM_REQ  size code of requester i in bits [2i+1:2i]: 01 large, 10 medium, 11 small, 00 no points
hit_ack  out  NUM_REQ  one-hot, one-cycle grant pulse
ship_hit  in  1  single-cycle pulse, ship destroyed
score_bcd  out  16  current score, 4 BCD digits, thousands in [15:12]
high_bcd  out  16  high score, 4 BCD digits
lives  out  3  remaining lives
state  out  2  00 IDLE, 01 PLAY, 10 DYING, 11 OVER
game_over  out  1  high while state==OVER

Behaviour:
- Reset (async): state=IDLE, score_bcd=0, high_bcd=0, lives=0, hit_ack=0, rr pointer=0.
- FSM:
  - IDLE/OVER + start -> PLAY. On that edge: score_bcd=0, lives=START_LIVES, rr pointer=0. high_bcd is kept.
  - PLAY + ship_hit -> lives-1. If the result is 0 -> OVER, else -> DYING with death counter=DEATH_CYCLES-1.
  - DYING: counter decrements each cycle. When the counter reaches 0 -> PLAY. ship_hit is ignored in DYING.
  - OVER entry: if score_bcd > high_bcd (unsigned compare of the BCD word), high_bcd <= score_bcd on the same edge that enters OVER.
  - start in PLAY/DYING is ignored.
- Arbitration:
  - Active only in PLAY.
  - Round-robin: search begins at the rr pointer. The first asserted hit_req wins.
  - hit_ack[winner] is asserted for exactly one cycle, combinationally from the registered pointer and hit_req.
  - On the acking edge the pointer becomes winner+1 mod NUM_REQ.
  - At most one grant per cycle.
  - A requester sees the ack and drops hit_req in the following cycle. If hit_req is still high after an ack, it is treated as a new hit.
  - In IDLE/DYING/OVER: hit_ack=0 and requests wait.
- Scoring:
  - On the acking edge, score_bcd <= BCD sum of score_bcd and the points for the winner's size code.
  - Latency: new score is visible the cycle after the ack.
  - Size 00: acked, score unchanged.
  - BCD add is per-digit with carry: a digit sum >9 subtracts 10 and carries.
  - Saturation: a carry out of the thousands digit saturates score_bcd at 16'h9999. It does not wrap.
- Simultaneous ship_hit and grant in the same PLAY cycle: the grant is scored on that edge and the ship_hit is processed on the same edge.
  - If that ship_hit ends the game, the high-score compare uses the post-add score.
- Reset mid-game: immediate return to IDLE; high_bcd is also cleared.

Test Plan:
- Reset then start=1 one cycle -> state=01, lives=3, score_bcd=0000, high_bcd=0000.
- PLAY, req0 held with size 11 -> hit_ack=0001 for one cycle, score_bcd=0100 next cycle; size 01 then 10 -> 0120, then 0170.
- PLAY, hit_req=1111 held continuously, all sizes 01 -> acks in order 0001,0010,0100,1000,0001; score increases by 0020 per cycle.
- score_bcd=9990, small hit -> score_bcd=9999. A further hit keeps 9999.
- ship_hit with lives=3 -> state=10, lives=2, no acks for 8 cycles despite hit_req; then state=01 and the pending req is acked.
- lives=1, score_bcd=0350, high_bcd=0200: ship_hit with a simultaneous medium grant -> state=11, game_over=1, score_bcd=0400, high_bcd=0400. Then start -> score_bcd=0000, high_bcd remains 0400.

Source files
------------

// File: rtl/score_ctrl_if.sv
// Hit-request / score bus between the collision logic, score controller and display side.
interface score_ctrl_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic                   start;
    logic [NUM_REQ-1:0]     hit_req;
    logic [2*NUM_REQ-1:0]   hit_size;
    logic [NUM_REQ-1:0]     hit_ack;
    logic                   ship_hit;
    logic [15:0]            score_bcd;
    logic [15:0]            high_bcd;
    logic [2:0]             lives;
    logic [1:0]             state;
    logic                   game_over;

    // Game/collision side: raises requests and events, observes grants and score.
    modport master (
        output start, hit_req, hit_size, ship_hit,
        input  hit_ack, score_bcd, high_bcd, lives, state, game_over
    );

    // Score controller side.
    modport slave (
        input  start, hit_req, hit_size, ship_hit,
        output hit_ack, score_bcd, high_bcd, lives, state, game_over
    );
endinterface

// File: rtl/score_ctrl.sv
// Score controller: round-robin hit arbitration, saturating BCD scoring,
// lives / high-score tracking and the idle/play/dying/over game FSM.
module score_ctrl #(
    parameter int unsigned NUM_REQ      = 4,
    parameter logic [15:0] PTS_LARGE    = 16'h0020,
    parameter logic [15:0] PTS_MED      = 16'h0050,
    parameter logic [15:0] PTS_SMALL    = 16'h0100,
    parameter int unsigned START_LIVES  = 3,
    parameter int unsigned DEATH_CYCLES = 8
) (
    input  logic         clk,
    input  logic         reset,
    score_ctrl_if.slave  bus
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (DEATH_CYCLES > 1) ? $clog2(DEATH_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_DYING = 2'b10,
        ST_OVER  = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        score_q, score_d;
    logic [15:0]        high_q, high_d;
    logic [2:0]         lives_q, lives_d;
    logic [PTR_W-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               grant_vld_c;
    logic [PTR_W-1:0]   grant_idx_c;
    logic [PTR_W-1:0]   cand_c;
    logic [NUM_REQ-1:0] ack_c;
    logic [1:0]         size_c;
    logic [15:0]        pts_c;

    // Per-digit BCD add; a carry out of the thousands digit pins the result at 9999.
    function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] sum;
        logic [4:0]  dsum;
        logic        carry;
        sum   = '0;
        carry = 1'b0;
        for (int d = 0; d < 4; d++) begin
            dsum = 5'(a[4*d +: 4]) + 5'(b[4*d +: 4]) + 5'(carry);
            if (dsum > 5'd9) begin
                dsum  = dsum - 5'd10;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            sum[4*d +: 4] = dsum[3:0];
        end
        return carry ? 16'h9999 : sum;
    endfunction

    // Round-robin search starting at the registered pointer; only grants in PLAY.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        cand_c      = '0;
        if (state_q == ST_PLAY) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand_c = PTR_W'((32'(rr_q) + k) % NUM_REQ);
                if (!grant_vld_c && bus.hit_req[cand_c]) begin
                    grant_vld_c = 1'b1;
                    grant_idx_c = cand_c;
                end
            end
        end
    end

    // One-hot grant and the size-weighted points of the winner.
    always_comb begin
        ack_c  = '0;
        size_c = 2'b00;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant_vld_c && (PTR_W'(k) == grant_idx_c)) begin
                ack_c[k] = 1'b1;
                size_c   = bus.hit_size[2*k +: 2];
            end
        end
        case (size_c)
            2'b01:   pts_c = PTS_LARGE;
            2'b10:   pts_c = PTS_MED;
            2'b11:   pts_c = PTS_SMALL;
            default: pts_c = 16'h0000;
        endcase
    end

    // Game FSM next state, scoring, lives and high score.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        high_d  = high_q;
        lives_d = lives_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    state_d = ST_PLAY;
                    score_d = 16'h0000;
                    lives_d = 3'(START_LIVES);
                    rr_d    = '0;
                end
            end
            ST_PLAY: begin
                if (grant_vld_c) begin
                    score_d = bcd_add_sat(score_q, pts_c);
                    rr_d    = (grant_idx_c == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx_c + PTR_W'(1);
                end
                // A same-cycle grant is already folded into score_d for the high-score compare.
                if (bus.ship_hit) begin
                    lives_d = lives_q - 3'd1;
                    if (lives_d == 3'd0) begin
                        state_d = ST_OVER;
                        if (score_d > high_q) begin
                            high_d = score_d;
                        end
                    end else begin
                        state_d = ST_DYING;
                        cnt_d   = CNT_W'(DEATH_CYCLES - 1);
                    end
                end
            end
            ST_DYING: begin
                if (cnt_q == '0) begin
                    state_d = ST_PLAY;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset also clears the high score.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            score_q <= 16'h0000;
            high_q  <= 16'h0000;
            lives_q <= 3'd0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            high_q  <= high_d;
            lives_q <= lives_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.hit_ack   = ack_c;
    assign bus.score_bcd = score_q;
    assign bus.high_bcd  = high_q;
    assign bus.lives     = lives_q;
    assign bus.state     = state_q;
    assign bus.game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_score_ctrl.sv
// Bench for score_ctrl: directed scenarios with literal expectations plus
// randomized play, all checked against a decimal-arithmetic game model.
module tb_score_ctrl;
    localparam int N      = 4;
    localparam int LIVES0 = 3;
    localparam int DEATH  = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    score_ctrl_if #(.NUM_REQ(N)) bus();

    score_ctrl #(
        .NUM_REQ(N), .PTS_LARGE(16'h0020), .PTS_MED(16'h0050), .PTS_SMALL(16'h0100),
        .START_LIVES(LIVES0), .DEATH_CYCLES(DEATH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: score/high kept as plain decimal integers.
    int m_state, m_score, m_high, m_lives, m_rr, m_dying, mw;

    function automatic int pts_of(input logic [1:0] s);
        case (s)
            2'b01:   return 20;
            2'b10:   return 50;
            2'b11:   return 100;
            default: return 0;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'(v / 1000);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic int winner();
        if (m_state != 1) return -1;
        for (int k = 0; k < N; k++) begin
            if (bus.hit_req[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ack();
        int w;
        w = winner();
        return (w < 0) ? 4'b0000 : 4'(1 << w);
    endfunction

    // Model update on each clock edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = 0; m_score = 0; m_high = 0; m_lives = 0; m_rr = 0; m_dying = 0;
        end else begin
            mw = winner();
            case (m_state)
                0, 3: if (bus.start) begin
                    m_state = 1; m_score = 0; m_lives = LIVES0; m_rr = 0;
                end
                1: begin
                    if (mw >= 0) begin
                        m_score = m_score + pts_of(2'(bus.hit_size >> (2 * mw)));
                        if (m_score > 9999) m_score = 9999;
                        m_rr = (mw + 1) % N;
                    end
                    if (bus.ship_hit) begin
                        m_lives = m_lives - 1;
                        if (m_lives == 0) begin
                            m_state = 3;
                            if (m_score > m_high) m_high = m_score;
                        end else begin
                            m_state = 2;
                            m_dying = DEATH;
                        end
                    end
                end
                default: begin
                    m_dying = m_dying - 1;
                    if (m_dying == 0) m_state = 1;
                end
            endcase
        end
    end

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model ack",   32'(bus.hit_ack),   32'(exp_ack()));
            chk("model score", 32'(bus.score_bcd), 32'(to_bcd(m_score)));
            chk("model high",  32'(bus.high_bcd),  32'(to_bcd(m_high)));
            chk("model lives", 32'(bus.lives),     32'(m_lives));
            chk("model state", 32'(bus.state),     32'(m_state));
            chk("model over",  32'(bus.game_over), 32'(m_state == 3));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic hit(input int idx, input logic [1:0] sz);
        bus.hit_req  = 4'(1 << idx);
        bus.hit_size = 8'(sz) << (2 * idx);
        #1 chk("hit ack", 32'(bus.hit_ack), 32'(1 << idx));
        tick();
        bus.hit_req = '0;
    endtask

    task automatic lose_life();
        bus.ship_hit = 1'b1;
        tick();
        bus.ship_hit = 1'b0;
        for (int i = 0; i < 20 && bus.state == 2'b10; i++) tick();
        chk("dying exit bound", 32'(bus.state == 2'b10), 32'd0);
    endtask

    logic [15:0] exp_sc [5];

    initial begin
        exp_sc = '{16'h0190, 16'h0210, 16'h0230, 16'h0250, 16'h0270};
        bus.start = 1'b0; bus.hit_req = '0; bus.hit_size = '0; bus.ship_hit = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        chk_en = 1'b1;
        tick(); tick();
        chk("reset state", 32'(bus.state), 32'h0);
        chk("reset score", 32'(bus.score_bcd), 32'h0);
        chk("reset high",  32'(bus.high_bcd), 32'h0);
        chk("reset lives", 32'(bus.lives), 32'h0);
        chk("reset ack",   32'(bus.hit_ack), 32'h0);
        reset = 1'b0;
        tick();

        // Start a game.
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        chk("start state", 32'(bus.state), 32'h1);
        chk("start lives", 32'(bus.lives), 32'd3);
        chk("start score", 32'(bus.score_bcd), 32'h0000);

        // Size weighting.
        hit(0, 2'b11); chk("small score", 32'(bus.score_bcd), 32'h0100);
        hit(0, 2'b01); chk("large score", 32'(bus.score_bcd), 32'h0120);
        hit(0, 2'b10); chk("med score",   32'(bus.score_bcd), 32'h0170);
        hit(3, 2'b01); chk("req3 score",  32'(bus.score_bcd), 32'h0190);

        // All requesters held: rotation from pointer 0.
        bus.hit_req = 4'hF; bus.hit_size = 8'h55;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr ack",   32'(bus.hit_ack), 32'(1 << (k % 4)));
            chk("rr score", 32'(bus.score_bcd), 32'(exp_sc[k]));
            tick();
        end
        bus.hit_req = '0;
        chk("rr final score", 32'(bus.score_bcd), 32'h0290);

        // Climb to 9990 and saturate.
        bus.hit_req = 4'b0001; bus.hit_size = 8'h03;
        repeat (97) tick();
        bus.hit_req = '0;
        chk("pre-sat score", 32'(bus.score_bcd), 32'h9990);
        hit(0, 2'b11); chk("sat score",  32'(bus.score_bcd), 32'h9999);
        hit(0, 2'b11); chk("sat hold",   32'(bus.score_bcd), 32'h9999);

        // Ship hit: eight DYING cycles without grants, then the pending request.
        bus.ship_hit = 1'b1; tick(); bus.ship_hit = 1'b0;
        bus.hit_req = 4'b0010; bus.hit_size = 8'h04;
        chk("dying state", 32'(bus.state), 32'h2);
        chk("dying lives", 32'(bus.lives), 32'd2);
        for (int i = 0; i < DEATH; i++) begin
            #1;
            chk("dying no ack", 32'(bus.hit_ack), 32'h0);
            chk("dying hold",   32'(bus.state), 32'h2);
            tick();
        end
        #1;
        chk("revive state", 32'(bus.state), 32'h1);
        chk("revive ack",   32'(bus.hit_ack), 32'b0010);
        tick();
        bus.hit_req = '0;

        // Mid-game reset.
        reset = 1'b1;
        #1;
        chk("midreset state", 32'(bus.state), 32'h0);
        chk("midreset score", 32'(bus.score_bcd), 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // First game ends at 0200.
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        hit(0, 2'b11); hit(0, 2'b11);
        lose_life(); lose_life(); lose_life();
        chk("over state", 32'(bus.state), 32'h3);
        chk("over flag",  32'(bus.game_over), 32'h1);
        chk("over high",  32'(bus.high_bcd), 32'h0200);

        // Second game: final ship hit with a simultaneous medium grant.
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        chk("restart score", 32'(bus.score_bcd), 32'h0);
        chk("restart high",  32'(bus.high_bcd), 32'h0200);
        hit(0, 2'b11); hit(0, 2'b11); hit(0, 2'b11); hit(0, 2'b10);
        chk("g2 score", 32'(bus.score_bcd), 32'h0350);
        lose_life(); lose_life();
        chk("g2 lives", 32'(bus.lives), 32'd1);
        bus.ship_hit = 1'b1; bus.hit_req = 4'b0001; bus.hit_size = 8'h02;
        #1 chk("final ack", 32'(bus.hit_ack), 32'b0001);
        tick();
        bus.ship_hit = 1'b0; bus.hit_req = '0;
        chk("final state", 32'(bus.state), 32'h3);
        chk("final over",  32'(bus.game_over), 32'h1);
        chk("final score", 32'(bus.score_bcd), 32'h0400);
        chk("final high",  32'(bus.high_bcd), 32'h0400);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        chk("g3 score", 32'(bus.score_bcd), 32'h0000);
        chk("g3 high",  32'(bus.high_bcd), 32'h0400);

        // Randomized play.
        for (int c = 0; c < 3000; c++) begin
            bus.hit_req  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            bus.hit_size = 8'($urandom);
            bus.ship_hit = ($urandom_range(0, 15) == 0);
            bus.start    = ($urandom_range(0, 3) == 0);
            reset        = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0;
        bus.hit_req = '0; bus.ship_hit = 1'b0; bus.start = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
